// File: rtl/lo_pkg.sv
// Shared constants, FSM state type and one-hot helper for the button conditioner.
package lo_pkg;

  localparam int NUM_BUTTONS         = 9;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } lo_state_e;

  function automatic logic is_onehot(input logic [NUM_BUTTONS-1:0] v);
    return (v != '0) && ((v & (v - NUM_BUTTONS'(1))) == '0);
  endfunction

endpackage

// File: rtl/lo_debounce.sv
// One button bit: 2-flop synchronizer followed by a stable-count debouncer.
module lo_debounce
  import lo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_raw,
  output logic o_deb
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
    end else if (!i_ena) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_deb  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      // Any sample that agrees with the debounced level restarts the count.
      if (r_sync[1] != r_deb) begin
        if (r_cnt == LIMIT) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/lo_button_conditioner.sv
// Debounces 9 buttons and emits a single-cycle one-hot move per press; multi-button presses are rejected.
// Optional accepted-move counter enabled by defining LO_MOVE_COUNT_EN.
module lo_button_conditioner
  import lo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] press_onehot,
  output logic                   press_valid,
  output logic                   rejected
`ifdef LO_MOVE_COUNT_EN
  ,
  output logic [7:0]             move_count
`endif
);

  logic [NUM_BUTTONS-1:0] w_deb;
  lo_state_e              r_state;
  lo_state_e              w_state_nxt;
  logic [NUM_BUTTONS-1:0] w_press_nxt;
  logic                   w_rej_nxt;
  logic [NUM_BUTTONS-1:0] r_press;
  logic                   r_valid;
  logic                   r_rej;

  lo_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb [NUM_BUTTONS-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ena (ena),
    .i_raw (btn_raw),
    .o_deb (w_deb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_state <= IDLE;
    else if (!ena) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_deb != '0) w_state_nxt = HELD;
      HELD:    if (w_deb == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Only the IDLE->HELD transition can fire; presses added while HELD are ignored.
  always_comb begin
    w_press_nxt = '0;
    w_rej_nxt   = 1'b0;
    if (r_state == IDLE && w_deb != '0) begin
      if (is_onehot(w_deb)) w_press_nxt = w_deb;
      else                  w_rej_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press <= '0;
      r_valid <= 1'b0;
      r_rej   <= 1'b0;
    end else if (!ena) begin
      r_press <= '0;
      r_valid <= 1'b0;
      r_rej   <= 1'b0;
    end else begin
      r_press <= w_press_nxt;
      r_valid <= |w_press_nxt;
      r_rej   <= w_rej_nxt;
    end
  end

  assign press_onehot = r_press;
  assign press_valid  = r_valid;
  assign rejected     = r_rej;

`ifdef LO_MOVE_COUNT_EN
  logic [7:0] r_move_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_move_cnt <= '0;
    else if (!ena)           r_move_cnt <= '0;
    else if (|w_press_nxt)   r_move_cnt <= r_move_cnt + 8'd1;
  end

  assign move_count = r_move_cnt;
`endif

endmodule

// File: tb/tb_lo_button_conditioner.sv
// Randomized + directed bench for lo_button_conditioner (DEBOUNCE_CYCLES=4) against a behavioural model.
module tb_lo_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [8:0] btn_raw;
  logic [8:0] press_onehot;
  logic       press_valid;
  logic       rejected;
`ifdef LO_MOVE_COUNT_EN
  logic [7:0] move_count;
`endif

  lo_button_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_raw      (btn_raw),
    .press_onehot (press_onehot),
    .press_valid  (press_valid),
    .rejected     (rejected)
`ifdef LO_MOVE_COUNT_EN
    ,
    .move_count   (move_count)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // model: raw history -> synchronized view, per-bit stable-run counts, held flag
  logic [8:0] m_q[$];
  int         m_run[9];
  logic [8:0] m_deb;
  logic       m_held;
  logic [8:0] e_press;
  logic       e_rej;
  logic [7:0] m_cnt;

  int         n_pulse;
  int         n_rej;
  logic [8:0] last_press;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < 9; i++) m_run[i] = 0;
    m_deb   = '0;
    m_held  = 1'b0;
    e_press = '0;
    e_rej   = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic model_edge(input logic [8:0] raw, input logic en);
    logic [8:0] sync;
    if (!en) begin
      model_clear();
      return;
    end
    m_q.push_back(raw);
    if (m_q.size() > 3) void'(m_q.pop_front());
    sync = (m_q.size() == 3) ? m_q[0] : 9'h000;
    e_press = '0;
    e_rej   = 1'b0;
    if (!m_held && m_deb != 0) begin
      if ($countones(m_deb) == 1) e_press = m_deb;
      else                        e_rej   = 1'b1;
      m_held = 1'b1;
    end else if (m_held && m_deb == 0) begin
      m_held = 1'b0;
    end
    if (e_press != 0) m_cnt = m_cnt + 8'd1;
    for (int i = 0; i < 9; i++) begin
      if (sync[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_deb[i] = sync[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check_outs();
    chk("press_onehot", 32'(press_onehot), 32'(e_press));
    chk("press_valid",  32'(press_valid),  32'(e_press != 0));
    chk("rejected",     32'(rejected),     32'(e_rej));
    chk("debounced",    32'(dut.w_deb),    32'(m_deb));
`ifdef LO_MOVE_COUNT_EN
    chk("move_count",   32'(move_count),   32'(m_cnt));
`endif
  endtask

  task automatic step(input logic [8:0] raw, input logic en);
    btn_raw = raw;
    ena     = en;
    @(posedge clk);
    model_edge(raw, en);
    #1;
    check_outs();
    if (press_valid) begin
      n_pulse++;
      last_press = press_onehot;
    end
    if (rejected) n_rej++;
  endtask

  task automatic hold(input logic [8:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b1);
  endtask

  task automatic clr_counts();
    n_pulse    = 0;
    n_rej      = 0;
    last_press = '0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    rst_n   = 1'b0;
    ena     = 1'b1;
    btn_raw = '0;
    model_clear();
    clr_counts();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    rst_n = 1'b1;
    hold(9'h000, 3);

    // single press latency and no auto-repeat
    clr_counts();
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step(9'h010, 1'b1);
      if (press_valid && first == 0) first = k;
    end
    chk("latency", 32'(first), 32'(D + 3));
    chk("single_pulse", 32'(n_pulse), 32'd1);
    chk("pulse_value", 32'(last_press), 32'h010);
    hold(9'h000, 10);

    // short glitch is filtered
    clr_counts();
    hold(9'h001, 3);
    hold(9'h000, 12);
    chk("glitch_pulses", 32'(n_pulse), 32'd0);
    chk("glitch_deb", 32'(dut.w_deb), 32'd0);

    // simultaneous two-button press rejected, then single press accepted
    clr_counts();
    hold(9'h003, 15);
    chk("multi_rej", 32'(n_rej), 32'd1);
    chk("multi_pulses", 32'(n_pulse), 32'd0);
    hold(9'h000, 12);
    hold(9'h100, 12);
    chk("after_rej_pulse", 32'(last_press), 32'h100);
    chk("after_rej_count", 32'(n_pulse), 32'd1);
    hold(9'h000, 12);

    // extra button while held is ignored
    clr_counts();
    hold(9'h001, 10);
    hold(9'h003, 12);
    chk("held_pulses", 32'(n_pulse), 32'd1);
    chk("held_value", 32'(last_press), 32'h001);
    chk("held_rej", 32'(n_rej), 32'd0);
    hold(9'h000, 12);
    hold(9'h002, 12);
    chk("second_value", 32'(last_press), 32'h002);
    chk("second_pulses", 32'(n_pulse), 32'd2);
    hold(9'h000, 12);

    // reset mid-debounce, then reset while pulse is high; held button re-accepted
    hold(9'h010, 3);
    async_reset();
    clr_counts();
    first = 0;
    for (int k = 1; k <= D + 3; k++) step(9'h010, 1'b1);
    chk("pulse_before_rst", 32'(press_onehot), 32'h010);
    async_reset();
    for (int k = 1; k <= 15; k++) begin
      step(9'h010, 1'b1);
      if (press_valid && first == 0) first = k;
    end
    chk("held_thru_rst_lat", 32'(first), 32'(D + 3));
    hold(9'h000, 12);

    // ena dropped while pulse is high
    for (int k = 1; k <= D + 3; k++) step(9'h020, 1'b1);
    chk("pulse_before_ena", 32'(press_onehot), 32'h020);
    step(9'h020, 1'b0);
    chk("ena_clear", 32'(press_onehot), 32'h000);
    hold(9'h020, 15);
    hold(9'h000, 12);

    // randomized patterns
    for (int it = 0; it < 300; it++) begin
      logic [8:0] pat;
      int sel;
      sel = $urandom_range(0, 7);
      pat = 9'h000;
      pat[$urandom_range(0, 8)] = 1'b1;
      if (sel >= 5) pat[$urandom_range(0, 8)] = 1'b1;
      if (sel == 7) step(pat, 1'b0);
      hold(pat, (sel == 4) ? $urandom_range(1, 3) : $urandom_range(1, 12));
      hold(9'h000, $urandom_range(1, 10));
    end

`ifdef LO_MOVE_COUNT_EN
    step(9'h000, 1'b0);
    clr_counts();
    for (int p = 0; p < 256; p++) begin
      hold(9'h001 << (p % 9), D + 4);
      hold(9'h000, D + 4);
    end
    chk("wrap_pulses", 32'(n_pulse), 32'd256);
    chk("wrap_count", 32'(move_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lo_button_conditioner.md
LO_BUTTON_CONDITIONER -- requirements
Module: lo_button_conditioner

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples needed to accept a level change (legal range 2..65535).
REQ-002 SHALL provide parameter CNT_W, default 16, width of each debounce counter, which SHALL be at least clog2(DEBOUNCE_CYCLES+1).
REQ-003 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  design enable; low means synchronous clear.
REQ-006 btn_raw  input  9  asynchronous raw button levels, bit i = field i+1, active-high.
REQ-007 press_onehot  output  9  single-cycle one-hot move command to the game stage; all-zero when idle.
REQ-008 press_valid  output  1  high exactly when press_onehot is non-zero.
REQ-009 rejected  output  1  one-cycle pulse when a multi-button press is discarded.
REQ-010 move_count  output  8  accepted-move counter; present only when LO_MOVE_COUNT_EN is defined.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Per bit, the debounce counter SHALL increment while the synchronized value differs from the debounced value, and SHALL clear when they match.
REQ-013 The debounced bit SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES; the counter SHALL then clear.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced value.
REQ-015 A control FSM SHALL have states IDLE (all debounced bits 0) and HELD (at least one debounced bit 1, awaiting full release).
REQ-016 IDLE->HELD SHALL occur when the debounced vector becomes non-zero; if that vector is one-hot, press_onehot SHALL equal it for exactly one cycle, on the next edge.
REQ-017 If that vector has two or more bits set, the press SHALL be discarded, press_onehot SHALL stay zero, and rejected SHALL pulse for one cycle.
REQ-018 HELD->IDLE SHALL occur only when the debounced vector is all-zero; additional presses while in HELD SHALL be ignored, so there is no auto-repeat.
REQ-019 Latency SHALL be DEBOUNCE_CYCLES+3 edges from the first edge sampling a stable new raw level to the press_onehot pulse.
REQ-020 press_onehot, press_valid and rejected SHALL be registered outputs, and at most one bit of press_onehot SHALL ever be high.
REQ-021 When ena is low, synchronizers, counters, debounced bits, FSM (to IDLE), outputs and move_count SHALL clear on the next edge.

Reset
REQ-022 rst_n low SHALL asynchronously force the synchronizers, counters and debounced bits to 0, the FSM to IDLE, press_onehot to 0, press_valid to 0, rejected to 0 and move_count to 0.
REQ-023 After rst_n deasserts, a button held through reset SHALL be treated as a new press once debounced, and SHALL be accepted if it is the only one held.

Configuration
REQ-024 With LO_MOVE_COUNT_EN defined, move_count SHALL increment by 1 on each accepted press, wrap 255->0, and not change on rejected presses.
REQ-025 Without LO_MOVE_COUNT_EN, the move_count port and its register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Shared package lo_pkg SHALL hold NUM_BUTTONS=9, the FSM state enum (IDLE, HELD) and the DEBOUNCE_CYCLES default constant.
REQ-027 Per-bit synchronizer plus debounce SHALL be sub-module lo_debounce, instantiated NUM_BUTTONS times; the FSM, one-hot check and counter SHALL live in the top.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Hold btn_raw=9'h010 stable -> press_onehot=9'h010 for exactly 1 cycle, 7 edges after the first sampling edge; press_valid high in the same cycle; no further pulse while held.
REQ-029 Drive btn_raw bit0 high for 3 cycles then low -> no pulse, debounced value stays 0.
REQ-030 Drive btn_raw=9'h003 in the same cycle and hold -> rejected pulses once, press_onehot stays 0, and after release plus a single press of 9'h100 -> press_onehot=9'h100.
REQ-031 Press 9'h001, then add 9'h002 while held -> single pulse of 9'h001 only; after full release, press 9'h002 -> pulse 9'h002.
REQ-032 Assert rst_n low mid-debounce, and separately drop ena for 1 cycle -> all outputs 0 immediately on reset and on the next edge for ena; with LO_MOVE_COUNT_EN, 256 accepted presses -> move_count wraps to 0.
